spi_xfer_ctrl: RTL and testbench
================================

// Module: spi_xfer_ctrl
// PURPOSE
//  Byte-stream front end for the SPI master. Queues TX bytes from the core and sequences one
//  SPI byte transfer per queued byte by driving spi_en/tx_data for a fixed cycle window.
//  Captures the master's rx_data after each window and returns it on a valid/ready stream.
//  Sits directly upstream of the SPI master, in the same clk domain.
// PARAMETERS
//  TX_DEPTH     4   TX FIFO entries; power of 2, >=2
//  RX_DEPTH     4   RX FIFO entries when SPI_XFER_RX_FIFO_EN is defined; power of 2, >=2
//  BYTE_CYCLES  20  clk cycles spi_en is held high per byte; >=1
//  GAP_CYCLES   4   clk cycles spi_en is held low after a byte, before rx_data is sampled; >=1
// PORTS
//  clk       in   1  system clock; all logic on posedge
//  rst_n     in   1  asynchronous active-low reset
//  s_valid   in   1  TX byte offered
//  s_data    in   8  TX byte
//  s_ready   out  1  TX FIFO not full; byte accepted when s_valid&s_ready
//  m_valid   out  1  RX byte available
//  m_data    out  8  RX byte, head of RX store
//  m_ready   in   1  consumer accepts; pop when m_valid&m_ready
//  spi_en    out  1  to SPI master: enable for the current byte window
//  tx_data   out  8  to SPI master: byte being sent; stable for the whole RUN window
//  rx_data   in   8  from SPI master: last received byte
//  busy      out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, both FIFOs empty, counters 0, spi_en=0, tx_data=0, m_valid=0,
//    m_data=0, busy=0, s_ready=1.
//  TX FIFO: circular pointers with an extra wrap bit. s_ready = !full; no same-cycle bypass.
//    A push and a pop in the same cycle are both honoured.
//  FSM:
//   IDLE    -> LOAD when TX FIFO is non-empty and the RX store has a free slot.
//   LOAD    1 cycle: tx_data <= FIFO head, pop the TX FIFO, cnt <= 0 -> RUN.
//   RUN     spi_en=1; cnt++ each cycle. When cnt==BYTE_CYCLES-1: spi_en<=0, cnt<=0 -> GAP.
//           spi_en is therefore high for exactly BYTE_CYCLES cycles.
//   GAP     spi_en=0; cnt++. When cnt==GAP_CYCLES-1 -> CAPTURE.
//   CAPTURE 1 cycle: write rx_data into the RX store.
//           -> LOAD if the TX FIFO is non-empty and the RX store is not full after this write.
//           -> IDLE otherwise.
//  Latency: a push into an empty, idle block raises spi_en 2 cycles later (IDLE->LOAD->RUN).
//    m_valid rises GAP_CYCLES+1 cycles after spi_en falls.
//  Byte pitch with back-to-back bytes: BYTE_CYCLES+GAP_CYCLES+2 cycles.
//  Backpressure: no RX byte is ever dropped. A byte is not started unless its RX slot is
//    guaranteed; when the RX store is full the FSM waits in IDLE.
//  tx_data holds its last value in IDLE. It changes only in LOAD.
//  Counters are $clog2 of the larger of BYTE_CYCLES and GAP_CYCLES, plus 1 bit; no wrap
//    is reachable.
//  Reset asserted mid-transfer: spi_en drops immediately (async), all queued data is
//    discarded, FSM returns to IDLE.
// CONFIGURATION
//  SPI_XFER_RX_FIFO_EN defined: the RX store is a FIFO of RX_DEPTH entries with the same
//    pointer scheme as TX; m_data is the FIFO head.
//  SPI_XFER_RX_FIFO_EN undefined: the RX store is a single holding register plus a valid
//    flag. "Full" means the flag is set, so each byte must be consumed before the next starts.
//    RX_DEPTH is ignored.
//  A simultaneous write in CAPTURE and a pop by m_ready are both honoured in either
//    configuration.
// TESTING
//  1. Reset, push 0xA5, m_ready=1, rx_data=0x3C:
//     spi_en high for exactly 20 cycles, tx_data=0xA5 throughout;
//     m_valid pulses with m_data=0x3C 5 cycles after spi_en falls.
//  2. Push 4 bytes back-to-back (0x01..0x04), m_ready=1:
//     s_ready falls after the 4th push only if no pop has occurred;
//     4 spi_en windows at a 26-cycle pitch; tx_data sequence 01,02,03,04; busy stays high
//     until the 4th CAPTURE.
//  3. FIFO build, m_ready=0, push 6 bytes:
//     exactly 4 transfers, then IDLE with busy=0 while 2 bytes remain queued;
//     raising m_ready drains RX and the remaining 2 transfers resume.
//  4. Register build, m_ready=0, push 2 bytes:
//     one transfer only; the second starts the cycle after the first m_valid&m_ready pop.
//  5. Assert rst_n low at cycle 10 of RUN:
//     spi_en, m_valid and busy go 0 immediately; s_ready=1; no capture occurs after release.
//  6. Push 0x00 and 0xFF with rx_data tied to 0x5A:
//     both captured values equal 0x5A; a push on a full TX FIFO is not accepted
//     (s_ready=0, FIFO contents unchanged).

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: byte-stream front end that sequences one SPI master byte window per queued TX byte
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_valid/s_data    TX byte stream in; s_ready is TX FIFO not full
//   m_valid/m_data    RX byte stream out (head of RX store); m_ready pops
//   spi_en, tx_data   to the SPI master: byte window enable and byte being sent
//   rx_data           from the SPI master: last received byte
//   busy              FSM not in IDLE
//
// Configuration macro SPI_XFER_RX_FIFO_EN: when defined the RX store is a RX_DEPTH-entry FIFO,
// otherwise it is a single holding register with a valid flag.
module spi_xfer_ctrl #(
    parameter int TX_DEPTH    = 4,
    parameter int RX_DEPTH    = 4,
    parameter int BYTE_CYCLES = 20,
    parameter int GAP_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       m_valid,
    output logic [7:0] m_data,
    input  logic       m_ready,
    output logic       spi_en,
    output logic [7:0] tx_data,
    input  logic [7:0] rx_data,
    output logic       busy
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int CW  = $clog2(BYTE_CYCLES > GAP_CYCLES ? BYTE_CYCLES : GAP_CYCLES) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, CAPTURE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          spi_en_q;
    logic [7:0]    tx_data_q;

    logic [7:0]    tx_mem_q [TX_DEPTH];
    logic [TAW:0]  tx_wp_q, tx_rp_q;
    logic          tx_empty, tx_full, tx_push, tx_pop;
    logic [7:0]    tx_head;

    logic          rx_wr, rx_pop, rx_full, rx_full_after;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign tx_empty = tx_wp_q == tx_rp_q;
    assign tx_full  = (tx_wp_q[TAW] != tx_rp_q[TAW]) && (tx_wp_q[TAW-1:0] == tx_rp_q[TAW-1:0]);
    assign tx_push  = s_valid && !tx_full;
    // LOAD is only entered with the TX FIFO non-empty, so this pop is always safe.
    assign tx_pop   = state_q == LOAD;
    assign tx_head  = tx_mem_q[tx_rp_q[TAW-1:0]];

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem_q[tx_wp_q[TAW-1:0]] <= s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
        end else begin
            if (tx_push)
                tx_wp_q <= tx_wp_q + (TAW+1)'(1);
            if (tx_pop)
                tx_rp_q <= tx_rp_q + (TAW+1)'(1);
        end
    end

    assign rx_wr  = state_q == CAPTURE;
    assign rx_pop = m_valid && m_ready;

`ifdef SPI_XFER_RX_FIFO_EN
    localparam int RAW = $clog2(RX_DEPTH);

    logic [7:0]   rx_mem_q [RX_DEPTH];
    logic [RAW:0] rx_wp_q, rx_rp_q, rx_cnt;

    // Occupancy never exceeds RX_DEPTH, so the top bit is set only when full.
    assign rx_cnt        = rx_wp_q - rx_rp_q;
    assign rx_full       = rx_cnt[RAW];
    // A slot was reserved before LOAD, so after this write the store is full only if it
    // held RX_DEPTH-1 entries and nothing is popped in the same cycle.
    assign rx_full_after = (rx_cnt == (RAW+1)'(RX_DEPTH - 1)) && !rx_pop;
    assign m_valid       = rx_wp_q != rx_rp_q;
    assign m_data        = rx_mem_q[rx_rp_q[RAW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp_q <= '0;
            rx_rp_q <= '0;
            for (int i = 0; i < RX_DEPTH; i++)
                rx_mem_q[i] <= '0;
        end else begin
            if (rx_wr) begin
                rx_mem_q[rx_wp_q[RAW-1:0]] <= rx_data;
                rx_wp_q <= rx_wp_q + (RAW+1)'(1);
            end
            if (rx_pop)
                rx_rp_q <= rx_rp_q + (RAW+1)'(1);
        end
    end
`else
    logic       rx_v_q;
    logic [7:0] rx_q;

    assign rx_full       = rx_v_q;
    // A single slot is always occupied right after a capture.
    assign rx_full_after = 1'b1;
    assign m_valid       = rx_v_q;
    assign m_data        = rx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_v_q <= 1'b0;
            rx_q   <= '0;
        end else begin
            if (rx_wr)
                rx_q <= rx_data;
            rx_v_q <= rx_wr || (rx_v_q && !rx_pop);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            spi_en_q  <= 1'b0;
            tx_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Start only when the RX slot for this byte is guaranteed.
                    if (!tx_empty && !rx_full)
                        state_q <= LOAD;
                end
                LOAD: begin
                    tx_data_q <= tx_head;
                    cnt_q     <= '0;
                    spi_en_q  <= 1'b1;
                    state_q   <= RUN;
                end
                RUN: begin
                    if (cnt_q == CW'(BYTE_CYCLES - 1)) begin
                        spi_en_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= GAP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                CAPTURE: state_q <= (!tx_empty && !rx_full_after) ? LOAD : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready = !tx_full;
    assign spi_en  = spi_en_q;
    assign tx_data = tx_data_q;
    assign busy    = state_q != IDLE;
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed self-checking bench for spi_xfer_ctrl
module tb_spi_xfer_ctrl;
`ifdef SPI_XFER_RX_FIFO_EN
    localparam int PITCH     = 26;
    localparam int BUSY_GAPS = 0;
    localparam int FILL_N    = 8;
`else
    localparam int PITCH     = 28;
    localparam int BUSY_GAPS = 6;
    localparam int FILL_N    = 5;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
    logic [7:0] s_data = '0, rx_data = '0;
    logic       s_ready, m_valid, spi_en, busy;
    logic [7:0] m_data, tx_data;

    int         checks = 0, errors = 0;
    int         cyc_n = 0, rise_n = 0, pop_n = 0;
    int         rise_t [64];
    logic [7:0] rise_d [64];
    logic [7:0] pop_d  [64];
    logic       busy_lo [4096];
    logic       en_d = 1'b0;

    spi_xfer_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .spi_en(spi_en), .tx_data(tx_data), .rx_data(rx_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Mid-cycle monitor: records spi_en rising edges, pops and busy level per cycle.
    always @(negedge clk) begin
        if (spi_en && !en_d && rise_n < 64) begin
            rise_t[rise_n] = cyc_n;
            rise_d[rise_n] = tx_data;
            rise_n++;
        end
        en_d = spi_en;
        if (m_valid && m_ready && pop_n < 64) begin
            pop_d[pop_n] = m_data;
            pop_n++;
        end
        if (cyc_n < 4096)
            busy_lo[cyc_n] = !busy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 500) begin
            cyc(1);
            n++;
        end
        check("push_timeout", n < 500, 1);
        cyc(1);
        s_valid = 1'b0;
    endtask

    task automatic wait_rises(input int target, input string tag);
        int n = 0;
        while (rise_n < target && n < 400) begin
            cyc(1);
            n++;
        end
        check(tag, rise_n, target);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 400) begin
            cyc(1);
            n++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        int b, p0, n, k, acc, bad, pc;
        logic r;
        // Reset state
        rx_data = 8'h3C;
        cyc(2);
        check("rst_spi_en", spi_en, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_s_ready", s_ready, 1);
        rst_n = 1'b1;
        cyc(2);

        // 1: single byte 0xA5, rx 0x3C
        m_ready = 1'b1;
        push(8'hA5);
        check("t1_idle_after_push", busy, 0);
        cyc(1);
        check("t1_load_busy", busy, 1);
        check("t1_load_en", spi_en, 0);
        cyc(1);
        n = 0;
        bad = 0;
        while (spi_en && n < 100) begin
            if (tx_data !== 8'hA5)
                bad++;
            n++;
            cyc(1);
        end
        check("t1_en_width", n, 20);
        check("t1_tx_data_stable", bad, 0);
        cyc(4);
        check("t1_m_valid_early", m_valid, 0);
        cyc(1);
        check("t1_m_valid", m_valid, 1);
        check("t1_m_data", m_data, 8'h3C);
        cyc(1);
        check("t1_m_valid_pulse", m_valid, 0);
        check("t1_busy_end", busy, 0);

        // 2: four back-to-back bytes
        b = rise_n;
        for (int i = 1; i <= 4; i++)
            push(8'(i));
        check("t2_s_ready_after_pop", s_ready, 1);
        wait_rises(b + 4, "t2_rises");
        wait_idle("t2_idle");
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_tx_data_%0d", i), rise_d[b+i], 8'(i + 1));
        for (int i = 1; i < 4; i++)
            check($sformatf("t2_pitch_%0d", i), rise_t[b+i] - rise_t[b+i-1], PITCH);
        acc = 0;
        for (int c = rise_t[b]; c < rise_t[b+3]; c++)
            acc += int'(busy_lo[c]);
        check("t2_busy_low_cycles", acc, BUSY_GAPS);
        cyc(3);

`ifdef SPI_XFER_RX_FIFO_EN
        // 3: FIFO build, RX backpressure with 6 bytes
        m_ready = 1'b0;
        b = rise_n;
        p0 = pop_n;
        for (int i = 0; i < 6; i++)
            push(8'h31 + 8'(i));
        wait_rises(b + 4, "t3_rises4");
        wait_idle("t3_idle");
        cyc(60);
        check("t3_only_four", rise_n - b, 4);
        check("t3_busy_low", busy, 0);
        check("t3_m_valid", m_valid, 1);
        check("t3_s_ready_queued", s_ready, 1);
        m_ready = 1'b1;
        wait_rises(b + 6, "t3_rises6");
        wait_idle("t3_idle2");
        cyc(3);
        check("t3_tx5", rise_d[b+4], 8'h35);
        check("t3_tx6", rise_d[b+5], 8'h36);
        check("t3_pops", pop_n - p0, 6);
`else
        // 4: register build, second byte waits for the first pop
        m_ready = 1'b0;
        b = rise_n;
        push(8'h11);
        push(8'h22);
        wait_rises(b + 1, "t4_rise1");
        wait_idle("t4_idle");
        cyc(60);
        check("t4_one_transfer", rise_n - b, 1);
        check("t4_busy_low", busy, 0);
        check("t4_m_valid", m_valid, 1);
        check("t4_m_data", m_data, 8'h3C);
        m_ready = 1'b1;
        cyc(1);
        pc = cyc_n;
        m_ready = 1'b0;
        check("t4_popped", m_valid, 0);
        cyc(1);
        check("t4_load_after_pop", busy, 1);
        wait_rises(b + 2, "t4_rise2");
        check("t4_start_time", rise_t[b+1], pc + 2);
        check("t4_tx2", rise_d[b+1], 8'h22);
        m_ready = 1'b1;
        wait_idle("t4_idle2");
        cyc(3);
`endif

        // 5: reset during RUN
        m_ready = 1'b1;
        push(8'h77);
        n = 0;
        while (!spi_en && n < 50) begin
            cyc(1);
            n++;
        end
        check("t5_en_seen", spi_en, 1);
        cyc(9);
        #2 rst_n = 1'b0;
        #1;
        check("t5_spi_en", spi_en, 0);
        check("t5_m_valid", m_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_s_ready", s_ready, 1);
        check("t5_tx_data", tx_data, 0);
        #10 rst_n = 1'b1;
        b = rise_n;
        cyc(50);
        check("t5_no_restart", rise_n - b, 0);
        check("t5_no_capture", m_valid, 0);
        check("t5_idle", busy, 0);

        // 6: extreme values and full TX FIFO
        rx_data = 8'h5A;
        b = rise_n;
        p0 = pop_n;
        push(8'h00);
        push(8'hFF);
        wait_rises(b + 2, "t6_rises");
        wait_idle("t6_idle");
        cyc(3);
        check("t6_pops", pop_n - p0, 2);
        check("t6_rx0", pop_d[p0], 8'h5A);
        check("t6_rx1", pop_d[p0+1], 8'h5A);
        check("t6_tx0", rise_d[b], 8'h00);
        check("t6_tx1", rise_d[b+1], 8'hFF);

        m_ready = 1'b0;
        b = rise_n;
        k = 0;
        n = 0;
        s_valid = 1'b1;
        s_data = 8'h80;
        while ((s_ready || busy) && n < 800) begin
            r = s_ready;
            cyc(1);
            n++;
            if (r) begin
                k++;
                s_data = 8'h80 + 8'(k);
            end
        end
        check("t6_fill_timeout", n < 800, 1);
        check("t6_accepted", k, FILL_N);
        acc = 0;
        repeat (5) begin
            acc += int'(s_ready);
            cyc(1);
        end
        check("t6_full_s_ready", acc, 0);
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_rises(b + FILL_N, "t6_drain_rises");
        wait_idle("t6_drain_idle");
        cyc(60);
        check("t6_no_extra", rise_n - b, FILL_N);
        for (int i = 0; i < FILL_N; i++)
            check($sformatf("t6_order_%0d", i), rise_d[b+i], 8'h80 + 8'(i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
